// File: rtl/cr_kme_ib_arb_pkg.sv
// cr_kme_ib_arb_pkg: shared FSM state encoding and stats counter width for the KME inbound arbiter
package cr_kme_ib_arb_pkg;
  typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_e;
  localparam int STAT_W = 16;
endpackage

// File: rtl/cr_kme_rr_pick.sv
// cr_kme_rr_pick: combinational round-robin picker, first request at or after start wins
module cr_kme_rr_pick
  import cr_kme_ib_arb_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] start,
  output logic [N_REQ-1:0]         gnt_oh,
  output logic [$clog2(N_REQ)-1:0] gnt_idx,
  output logic                     any
);
  localparam int IW = $clog2(N_REQ);
  int idx;
  // walk offsets from farthest to nearest so the nearest valid request is the last one kept
  always_comb begin
    gnt_oh = '0;
    gnt_idx = '0;
    idx = 0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = (int'(start) + k) % N_REQ;
      if (req[IW'(idx)]) begin
        gnt_oh = N_REQ'(1) << idx;
        gnt_idx = IW'(idx);
      end
    end
  end
  assign any = |req;
endmodule

// File: rtl/cr_kme_ib_arb.sv
// cr_kme_ib_arb: frame-atomic round-robin arbiter for the KME inbound stream; optional per-requester frame counters under CR_KME_IB_ARB_STATS_EN
`ifndef AXI_S_DP_DWIDTH
`define AXI_S_DP_DWIDTH 64
`endif
`ifndef AXI_S_TID_WIDTH
`define AXI_S_TID_WIDTH 1
`endif
`ifndef AXI_S_TSTRB_WIDTH
`define AXI_S_TSTRB_WIDTH 8
`endif
`ifndef AXI_S_USER_WIDTH
`define AXI_S_USER_WIDTH 8
`endif
module cr_kme_ib_arb
  import cr_kme_ib_arb_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int DATA_W = `AXI_S_DP_DWIDTH,
  parameter int TID_W  = `AXI_S_TID_WIDTH,
  parameter int STRB_W = `AXI_S_TSTRB_WIDTH,
  parameter int USER_W = `AXI_S_USER_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_REQ-1:0]           req_tvalid,
  output logic [N_REQ-1:0]           req_tready,
  input  logic [N_REQ-1:0]           req_tlast,
  input  logic [N_REQ*DATA_W-1:0]    req_tdata,
  input  logic [N_REQ*TID_W-1:0]     req_tid,
  input  logic [N_REQ*STRB_W-1:0]    req_tstrb,
  input  logic [N_REQ*USER_W-1:0]    req_tuser,
  output logic                       kme_ib_tvalid,
  input  logic                       kme_ib_tready,
  output logic                       kme_ib_tlast,
  output logic [DATA_W-1:0]          kme_ib_tdata,
  output logic [TID_W-1:0]           kme_ib_tid,
  output logic [STRB_W-1:0]          kme_ib_tstrb,
  output logic [USER_W-1:0]          kme_ib_tuser,
  output logic                       arb_idle,
  output logic [$clog2(N_REQ)-1:0]   arb_grant
`ifdef CR_KME_IB_ARB_STATS_EN
  ,
  output logic [N_REQ*STAT_W-1:0]    stat_frames
`endif
);
  localparam int IW = $clog2(N_REQ);
  arb_state_e state_q, state_d;
  logic [IW-1:0] gnt_q, gnt_d, last_q, last_d, start, pick_idx, sel;
  logic [N_REQ-1:0] pick_oh;
  logic pick_any, acc, sel_valid, sel_last, xfer, ob_valid_q;
  assign acc = !ob_valid_q || kme_ib_tready;
  assign start = (last_q == IW'(N_REQ - 1)) ? '0 : last_q + 1'b1;
  cr_kme_rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req     (req_tvalid),
    .start   (start),
    .gnt_oh  (pick_oh),
    .gnt_idx (pick_idx),
    .any     (pick_any)
  );
  assign sel       = (state_q == ARB_IDLE) ? pick_idx : gnt_q;
  assign sel_valid = (state_q == ARB_IDLE) ? pick_any : req_tvalid[gnt_q];
  assign sel_last  = req_tlast[sel];
  assign xfer      = sel_valid && acc;
  assign req_tready = ((state_q == ARB_IDLE) ? pick_oh : (N_REQ'(1) << gnt_q)) & {N_REQ{acc}};
  assign arb_idle  = (state_q == ARB_IDLE) && !ob_valid_q;
  assign arb_grant = gnt_q;
  // lock on a non-last beat, release and advance the round-robin pointer on a last beat
  always_comb begin
    state_d = xfer ? (sel_last ? ARB_IDLE : ARB_BUSY) : state_q;
    gnt_d   = (xfer && !sel_last) ? sel : gnt_q;
    last_d  = (xfer && sel_last) ? sel : last_q;
  end
  // FSM state, lock owner and round-robin pointer
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ARB_IDLE;
      gnt_q   <= '0;
      last_q  <= IW'(N_REQ - 1);
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
    end
  end
  // single output stage: load on every transfer, drain when downstream takes it
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ob_valid_q    <= 1'b0;
      kme_ib_tlast  <= 1'b0;
      kme_ib_tdata  <= '0;
      kme_ib_tid    <= '0;
      kme_ib_tstrb  <= '0;
      kme_ib_tuser  <= '0;
    end else if (xfer) begin
      ob_valid_q    <= 1'b1;
      kme_ib_tlast  <= sel_last;
      kme_ib_tdata  <= req_tdata[int'(sel)*DATA_W +: DATA_W];
      kme_ib_tid    <= req_tid[int'(sel)*TID_W +: TID_W];
      kme_ib_tstrb  <= req_tstrb[int'(sel)*STRB_W +: STRB_W];
      kme_ib_tuser  <= req_tuser[int'(sel)*USER_W +: USER_W];
    end else if (kme_ib_tready) begin
      ob_valid_q    <= 1'b0;
    end
  end
  assign kme_ib_tvalid = ob_valid_q;
`ifdef CR_KME_IB_ARB_STATS_EN
  for (genvar i = 0; i < N_REQ; i++) begin : g_stat
    logic [STAT_W-1:0] cnt_q;
    // saturating count of frames completed by requester i
    always_ff @(posedge clk) begin
      if (!rst_n) cnt_q <= '0;
      else if (xfer && sel_last && sel == IW'(i) && cnt_q != '1) cnt_q <= cnt_q + 1'b1;
    end
    assign stat_frames[i*STAT_W +: STAT_W] = cnt_q;
  end
`endif
endmodule

// File: tb/tb_cr_kme_ib_arb.sv
// tb_cr_kme_ib_arb: table-driven and scoreboarded checks of the KME inbound arbiter
module tb_cr_kme_ib_arb;
  logic clk, rst_n;
  logic [3:0] req_tvalid, req_tready, req_tlast;
  logic [255:0] req_tdata;
  logic [3:0] req_tid;
  logic [31:0] req_tstrb, req_tuser;
  logic kme_ib_tvalid, kme_ib_tready, kme_ib_tlast, arb_idle;
  logic [63:0] kme_ib_tdata;
  logic [0:0] kme_ib_tid;
  logic [7:0] kme_ib_tstrb, kme_ib_tuser;
  logic [1:0] arb_grant;
`ifdef CR_KME_IB_ARB_STATS_EN
  logic [63:0] stat_frames;
`endif
  cr_kme_ib_arb #(.N_REQ(4), .DATA_W(64), .TID_W(1), .STRB_W(8), .USER_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_tvalid(req_tvalid), .req_tready(req_tready), .req_tlast(req_tlast),
    .req_tdata(req_tdata), .req_tid(req_tid), .req_tstrb(req_tstrb), .req_tuser(req_tuser),
    .kme_ib_tvalid(kme_ib_tvalid), .kme_ib_tready(kme_ib_tready), .kme_ib_tlast(kme_ib_tlast),
    .kme_ib_tdata(kme_ib_tdata), .kme_ib_tid(kme_ib_tid), .kme_ib_tstrb(kme_ib_tstrb),
    .kme_ib_tuser(kme_ib_tuser), .arb_idle(arb_idle), .arb_grant(arb_grant)
`ifdef CR_KME_IB_ARB_STATS_EN
    , .stat_frames(stat_frames)
`endif
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {logic [63:0] d; logic l; logic [7:0] u;} exp_t;
  typedef struct {logic [3:0] v; logic kr; logic [3:0] exp;} vec_t;
  exp_t sb[$];
  vec_t tbl[7];
  logic [63:0] sd[4][16];
  logic sl[4][16];
  int hd[4], tl[4];
  logic [3:0] en, fire;
  logic kr;
  int n_vec, n_err;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic add(int r, logic [63:0] d, logic l);
    sd[r][tl[r]] = d;
    sl[r][tl[r]] = l;
    tl[r]++;
  endtask

  task automatic expect_beat(logic [63:0] d, logic l, int r);
    exp_t e;
    e.d = d; e.l = l; e.u = 8'(r);
    sb.push_back(e);
  endtask

  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      req_tvalid[i] = (hd[i] < tl[i]) && en[i];
      req_tdata[i*64 +: 64] = (hd[i] < tl[i]) ? sd[i][hd[i]] : 64'h0;
      req_tlast[i] = (hd[i] < tl[i]) ? sl[i][hd[i]] : 1'b0;
      req_tuser[i*8 +: 8] = 8'(i);
      req_tstrb[i*8 +: 8] = 8'hff;
      req_tid[i] = 1'b0;
    end
    kme_ib_tready = kr;
  endtask

  task automatic redrive();
    drive();
    #1;
    fire = req_tvalid & req_tready;
  endtask

  task automatic observe();
    exp_t e;
    fire = req_tvalid & req_tready;
    if (kme_ib_tvalid && kme_ib_tready) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL sb_underflow: got beat %h expected no beat", kme_ib_tdata);
      end else begin
        e = sb.pop_front();
        chk("sb_data", kme_ib_tdata, e.d);
        chk("sb_last", 64'(kme_ib_tlast), 64'(e.l));
        chk("sb_user", 64'(kme_ib_tuser), 64'(e.u));
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) if (fire[i]) hd[i]++;
    drive();
    @(negedge clk);
    observe();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    kr = 1'b1;
    en = 4'hf;
    fire = '0;
    for (int i = 0; i < 4; i++) begin hd[i] = 0; tl[i] = 0; end
    sb.delete();
    drive();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic run_drain(string nm, int budget);
    for (int c = 0; c < budget && sb.size() != 0; c++) cycle();
    chk(nm, 64'(sb.size()), 64'h0);
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    tbl[0] = '{4'b0000, 1'b1, 4'b0000};
    tbl[1] = '{4'b0001, 1'b1, 4'b0001};
    tbl[2] = '{4'b0110, 1'b1, 4'b0010};
    tbl[3] = '{4'b1100, 1'b1, 4'b0100};
    tbl[4] = '{4'b1000, 1'b1, 4'b1000};
    tbl[5] = '{4'b1111, 1'b1, 4'b0001};
    tbl[6] = '{4'b1010, 1'b0, 4'b0010};
    do_reset();
    chk("rst_tvalid", 64'(kme_ib_tvalid), 64'h0);
    chk("rst_tready", 64'(req_tready), 64'h0);
    chk("rst_idle", 64'(arb_idle), 64'h1);
    chk("rst_grant", 64'(arb_grant), 64'h0);
    chk("rst_tdata", kme_ib_tdata, 64'h0);
    chk("rst_tlast", 64'(kme_ib_tlast), 64'h0);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      req_tvalid = tbl[i].v;
      kme_ib_tready = tbl[i].kr;
      #1;
      chk($sformatf("tbl%0d_tready", i), 64'(req_tready), 64'(tbl[i].exp));
      req_tvalid = '0;
      kme_ib_tready = 1'b1;
    end

    do_reset();
    add(0, 64'h11, 1'b0); add(0, 64'h22, 1'b0); add(0, 64'h33, 1'b1);
    expect_beat(64'h11, 1'b0, 0); expect_beat(64'h22, 1'b0, 0); expect_beat(64'h33, 1'b1, 0);
    redrive();
    cycle();
    chk("t1_latency_tvalid", 64'(kme_ib_tvalid), 64'h1);
    cycle();
    cycle();
    chk("t1_idle_c3", 64'(arb_idle), 64'h0);
    cycle();
    chk("t1_idle_c4", 64'(arb_idle), 64'h1);
    chk("t1_tvalid_c4", 64'(kme_ib_tvalid), 64'h0);
    chk("t1_drained", 64'(sb.size()), 64'h0);

    do_reset();
    add(0, 64'hA0, 1'b0); add(0, 64'hA1, 1'b1); add(0, 64'hA2, 1'b0); add(0, 64'hA3, 1'b1);
    add(2, 64'hB0, 1'b0); add(2, 64'hB1, 1'b1); add(2, 64'hB2, 1'b0); add(2, 64'hB3, 1'b1);
    expect_beat(64'hA0, 1'b0, 0); expect_beat(64'hA1, 1'b1, 0);
    expect_beat(64'hB0, 1'b0, 2); expect_beat(64'hB1, 1'b1, 2);
    expect_beat(64'hA2, 1'b0, 0); expect_beat(64'hA3, 1'b1, 0);
    expect_beat(64'hB2, 1'b0, 2); expect_beat(64'hB3, 1'b1, 2);
    redrive();
    for (int c = 0; c < 8; c++) cycle();
    chk("t2_no_bubble", 64'(sb.size()), 64'h0);

    do_reset();
    add(1, 64'hC0, 1'b0); add(1, 64'hC1, 1'b0); add(1, 64'hC2, 1'b1);
    add(3, 64'hD0, 1'b1);
    expect_beat(64'hC0, 1'b0, 1); expect_beat(64'hC1, 1'b0, 1);
    expect_beat(64'hC2, 1'b1, 1); expect_beat(64'hD0, 1'b1, 3);
    redrive();
    cycle();
    chk("t3_grant", 64'(arb_grant), 64'h1);
    en[1] = 1'b0;
    redrive();
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("t3_r3_blocked%0d", c), 64'(req_tready[3]), 64'h0);
      cycle();
    end
    en[1] = 1'b1;
    redrive();
    run_drain("t3_order", 12);

    do_reset();
    add(0, 64'hE0, 1'b0); add(0, 64'hE1, 1'b0); add(0, 64'hE2, 1'b0); add(0, 64'hE3, 1'b1);
    expect_beat(64'hE0, 1'b0, 0); expect_beat(64'hE1, 1'b0, 0);
    expect_beat(64'hE2, 1'b0, 0); expect_beat(64'hE3, 1'b1, 0);
    redrive();
    kr = 1'b0;
    for (int c = 0; c < 4; c++) begin
      cycle();
      chk($sformatf("t4_hold%0d", c), kme_ib_tdata, 64'hE0);
      chk($sformatf("t4_stall%0d", c), 64'(req_tready), 64'h0);
    end
    kr = 1'b1;
    run_drain("t4_drain", 12);

    do_reset();
    for (int i = 0; i < 4; i++) begin
      add(i, 64'hF0 + 64'(i), 1'b1);
      expect_beat(64'hF0 + 64'(i), 1'b1, i);
    end
    redrive();
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk($sformatf("t5_valid%0d", i), 64'(kme_ib_tvalid), 64'h1);
      chk($sformatf("t5_src%0d", i), 64'(kme_ib_tuser), 64'(i));
    end
    cycle();
    chk("t5_idle", 64'(arb_idle), 64'h1);
`ifdef CR_KME_IB_ARB_STATS_EN
    for (int i = 0; i < 4; i++) chk($sformatf("t5_stat%0d", i), 64'(stat_frames[i*16 +: 16]), 64'h1);
`endif

    do_reset();
    add(2, 64'h60, 1'b0); add(2, 64'h61, 1'b0); add(2, 64'h62, 1'b0); add(2, 64'h63, 1'b1);
    expect_beat(64'h60, 1'b0, 2); expect_beat(64'h61, 1'b0, 2);
    redrive();
    cycle();
    cycle();
    chk("t6_busy_grant", 64'(arb_grant), 64'h2);
    chk("t6_busy_data", kme_ib_tdata, 64'h61);
    rst_n = 1'b0;
    cycle();
    chk("t6_rst_tvalid", 64'(kme_ib_tvalid), 64'h0);
    chk("t6_rst_idle", 64'(arb_idle), 64'h1);
    chk("t6_rst_grant", 64'(arb_grant), 64'h0);
    chk("t6_rst_tdata", kme_ib_tdata, 64'h0);
`ifdef CR_KME_IB_ARB_STATS_EN
    chk("t6_rst_stats", stat_frames, 64'h0);
`endif
    do_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/cr_kme_ib_arb.md
# cr_kme_ib_arb

Frame-atomic round-robin arbiter that shares the single KME inbound AXI-stream port (`kme_ib_*` of `cr_kme`) among `N_REQ` upstream requesters. It sits directly in front of `cr_kme` in the KME top level. It locks the grant from the first accepted beat of a frame until its `tlast` beat. Output is registered (one pipeline stage) at full 1-beat/cycle throughput.

## Interface

Parameters:
- `N_REQ`, 4: number of requester streams, 2..8.
- `DATA_W`, `` `AXI_S_DP_DWIDTH `` (64): tdata width.
- `TID_W`, `` `AXI_S_TID_WIDTH `` (1): tid width.
- `STRB_W`, `` `AXI_S_TSTRB_WIDTH `` (8): tstrb width.
- `USER_W`, `` `AXI_S_USER_WIDTH `` (8): tuser width.

Ports:
- `clk` in 1: single clock; all logic on rising edge.
- `rst_n` in 1: reset is synchronous and active-low.
- `req_tvalid` in `N_REQ`: per-requester valid.
- `req_tready` out `N_REQ`: per-requester ready.
- `req_tlast` in `N_REQ`: per-requester last.
- `req_tdata` in `N_REQ*DATA_W`: packed data; requester i at `[i*DATA_W +: DATA_W]`.
- `req_tid` in `N_REQ*TID_W`: packed tid.
- `req_tstrb` in `N_REQ*STRB_W`: packed tstrb.
- `req_tuser` in `N_REQ*USER_W`: packed tuser.
- `kme_ib_tvalid` out 1: stream to `cr_kme`.
- `kme_ib_tready` in 1: ready from `cr_kme`.
- `kme_ib_tlast` out 1: stream to `cr_kme`.
- `kme_ib_tdata` out `DATA_W`: stream to `cr_kme`.
- `kme_ib_tid` out `TID_W`: stream to `cr_kme`.
- `kme_ib_tstrb` out `STRB_W`: stream to `cr_kme`.
- `kme_ib_tuser` out `USER_W`: stream to `cr_kme`.
- `arb_idle` out 1: high when state IDLE and the output register is empty.
- `arb_grant` out `$clog2(N_REQ)`: currently locked requester index. Valid only in BUSY.

## Operation

- FSM states:
  - IDLE: no frame in progress.
  - BUSY: locked to `gnt_q`.
- Stage-accept condition: `acc = !ob_valid_q || kme_ib_tready`.
- Arbitration happens in IDLE only, combinationally in the same cycle:
  - Candidate set is `req_tvalid`.
  - Search starts at `(last_q+1) mod N_REQ` and takes the first valid requester.
  - The winner's `req_tready = acc`; all other `req_tready` are 0.
- Beat transfer (requester i valid & ready):
  - Beat is loaded into the output register.
  - If tlast=0: go to BUSY with `gnt_q=i`.
  - If tlast=1: single-beat frame; stay in IDLE and set `last_q=i`.
- In BUSY:
  - Only `req_tready[gnt_q] = acc`.
  - When the `gnt_q` beat with tlast=1 transfers: go to IDLE and set `last_q=gnt_q`.
- A locked requester dropping tvalid mid-frame holds the lock. Other requesters stall indefinitely; no timeout.
- All sideband fields (tid, tstrb, tuser, tlast) pass through unmodified from the granted requester.
- Output register:
  - Loaded on every transfer.
  - `ob_valid_q` clears when `kme_ib_tready` is high and no new beat is loaded.

## Timing

- Latency: requester beat accepted in cycle N appears on `kme_ib_*` in cycle N+1.
- Throughput: 1 beat/cycle when `kme_ib_tready` is held high, including back-to-back frames from different requesters. There is no arbitration bubble.
- `req_tready` depends combinationally on `kme_ib_tready`.
- Outputs never change while `kme_ib_tvalid && !kme_ib_tready`.
- Reset values:
  - `kme_ib_tvalid=0`, `req_tready=0`, `arb_idle=1`, `arb_grant=0`.
  - `kme_ib_tdata`, `kme_ib_tid`, `kme_ib_tstrb`, `kme_ib_tuser`, `kme_ib_tlast` = 0.
  - State IDLE, `last_q=N_REQ-1`, so requester 0 wins first.
- Reset mid-frame: the lock and any pending output beat are discarded. The downstream frame is left truncated; system reset covers `cr_kme` too.
- Simultaneous events: an output beat draining and a new beat loading in the same cycle keeps `ob_valid_q=1`.

## Configuration

- Macro: `CR_KME_IB_ARB_STATS_EN`.
- When defined, port `stat_frames` (out, `N_REQ*16`) is added:
  - One 16-bit saturating count per requester of completed frames (tlast beats transferred).
  - Count stops at 0xFFFF.
  - Counts reset to 0.
- When undefined, the port and counters are absent. Arbitration behaviour is identical either way.

## Structure

- Shared package `cr_kme_ib_arb_pkg`:
  - FSM state enum (`ARB_IDLE`, `ARB_BUSY`).
  - Stats counter width constant (16).
- Sub-module `cr_kme_rr_pick`: combinational round-robin priority picker taking `N_REQ` requests and a start index, returning one-hot and binary grant.

## Test plan

1. After reset, only requester 0 valid with a 3-beat frame (tdata 0x11, 0x22, 0x33) and tready=1: the beats exit on cycles 1–3 unmodified, and `arb_idle` returns to 1 on cycle 4.
2. Requesters 0 and 2 both valid continuously with 2-beat frames: output frame order is 0, 2, 0, 2. Beats are never interleaved within a frame.
3. Requester 1 is in BUSY and drops tvalid for 5 cycles mid-frame while requester 3 is valid: `req_tready[3]` stays 0 and the frame from requester 1 completes first.
4. `kme_ib_tready` is held 0 for 4 cycles with a beat pending: `kme_ib_tdata` stays stable, and all `req_tready` are 0 after the output register fills.
5. Single-beat frames (tlast on every beat) from all 4 requesters with tready=1: grants go 0, 1, 2, 3 on consecutive cycles with no bubble.
6. `rst_n` asserted low during beat 2 of 4: the next cycle shows `kme_ib_tvalid=0` and state IDLE. With `CR_KME_IB_ARB_STATS_EN` defined, `stat_frames` reads 0.
